// File: rtl/chan_switch_seq_pkg.sv
// Shared definitions for the channel switch sequencer.
//   state_t     : sequencer state encoding
//   CH1..CH3    : channel codes carried on `change` and `sel_req`
//   CH_ILLEGAL  : request code that is always rejected
//   onehot()    : channel code -> chan_en pattern (bit0 = ch1)
package chan_switch_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    GUARD  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [1:0] CH1        = 2'b00;
  localparam logic [1:0] CH2        = 2'b01;
  localparam logic [1:0] CH3        = 2'b10;
  localparam logic [1:0] CH_ILLEGAL = 2'b11;

  // The illegal code maps to "nothing enabled" so it can never light an enable.
  function automatic logic [2:0] onehot(input logic [1:0] code);
    logic [2:0] en;
    case (code)
      CH1:     en = 3'b001;
      CH2:     en = 3'b010;
      CH3:     en = 3'b100;
      default: en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/chan_switch_seq_if.sv
// Control/handshake bundle between the host side and the channel switch
// sequencer.
//   master : host / channel side (drives requests, busy, start_in, flag_clr)
//   slave  : sequencer side (drives ack/err, start pulses, select, enables, flags)
interface chan_switch_seq_if;

  logic [1:0] sel_req;
  logic       sel_valid;
  logic       sel_ack;
  logic       sel_err;
  logic       busy1;
  logic       busy2;
  logic       busy3;
  logic       start_in;
  logic       start1;
  logic       start2;
  logic       start3;
  logic [1:0] change;
  logic [2:0] chan_en;
  logic       switching;
  logic       timeout_flag;
  logic       drop_flag;
  logic       flag_clr;

  modport master (
    output sel_req, sel_valid, busy1, busy2, busy3, start_in, flag_clr,
    input  sel_ack, sel_err, start1, start2, start3, change, chan_en,
           switching, timeout_flag, drop_flag
  );

  modport slave (
    input  sel_req, sel_valid, busy1, busy2, busy3, start_in, flag_clr,
    output sel_ack, sel_err, start1, start2, start3, change, chan_en,
           switching, timeout_flag, drop_flag
  );

endinterface

// File: rtl/chan_switch_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
// Shared by the drain timeout and the guard interval.
//   clk_sys : clock
//   rst_n   : synchronous reset, active-low
//   clr     : load zero (wins over en)
//   en      : count up by one, holding at all-ones
//   tc_val  : terminal value to compare against
//   cnt     : current count
//   tc      : cnt == tc_val
module chan_switch_cnt #(
  parameter int CNT_W = 13
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/chan_switch_seq.sv
// Channel switch sequencer: moves the active acquisition channel between
// ch1/ch2/ch3 so that the old channel drains, a dead-time with all enables
// low follows, the mux select settles, and only then the new enable rises.
// Host start pulses are forwarded to the active channel only.
//   clk_sys : system clock
//   rst_n   : synchronous reset, active-low
//   bus     : chan_switch_seq_if.slave (request/ack, busy, starts, select,
//             enables, sticky flags)
//
// state  | meaning
// RUN    | active channel enabled, requests and starts accepted
// DRAIN  | all enables low, waiting for old channel busy to fall (bounded)
// GUARD  | dead-time with all enables low; select moves on the last cycle
// COMMIT | select already stable, raise the new enable and acknowledge
module chan_switch_seq
  import chan_switch_seq_pkg::*;
#(
  parameter int GUARD_CYC   = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input logic              clk_sys,
  input logic              rst_n,
  chan_switch_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] GUARD_TC   = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [1:0] target;
  logic [1:0] change_q;
  logic [2:0] chan_en_q;
  logic [2:0] start_q;
  logic       ack_q;
  logic       err_q;
  logic       switching_q;
  logic       timeout_q;
  logic       drop_q;

  logic             busy_old;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_tc_val;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;

  // change never holds the illegal code, so default covers ch3 only.
  always_comb begin
    case (change_q)
      CH1:     busy_old = bus.busy1;
      CH2:     busy_old = bus.busy2;
      default: busy_old = bus.busy3;
    endcase
  end

  // The counter is cleared on every state exit so each phase starts at zero.
  always_comb begin
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    cnt_tc_val = GUARD_TC;
    case (state)
      DRAIN: begin
        cnt_tc_val = TIMEOUT_TC;
        if (busy_old && !cnt_tc) begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      GUARD: begin
        cnt_tc_val = GUARD_TC;
        if (!cnt_tc) begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  chan_switch_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .tc_val  (cnt_tc_val),
    .cnt     (cnt_val),
    .tc      (cnt_tc)
  );

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= RUN;
      target      <= CH1;
      change_q    <= CH1;
      chan_en_q   <= 3'b001;
      start_q     <= 3'b000;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      switching_q <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 3'b000;

      if (bus.flag_clr) begin
        timeout_q <= 1'b0;
        drop_q    <= 1'b0;
      end

      case (state)
        RUN: begin
          // A start issued with a switching request still goes to the old channel.
          if (bus.start_in) start_q <= onehot(change_q);
          if (bus.sel_valid) begin
            if (bus.sel_req == CH_ILLEGAL) begin
              err_q <= 1'b1;
            end else if (bus.sel_req == change_q) begin
              ack_q <= 1'b1;
            end else begin
              target      <= bus.sel_req;
              chan_en_q   <= 3'b000;
              switching_q <= 1'b1;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!busy_old) begin
            state <= GUARD;
          end else if (cnt_tc) begin
            timeout_q <= 1'b1;
            state     <= GUARD;
          end
        end
        GUARD: begin
          if (cnt_tc) begin
            change_q <= target;
            state    <= COMMIT;
          end
        end
        COMMIT: begin
          chan_en_q   <= onehot(target);
          ack_q       <= 1'b1;
          switching_q <= 1'b0;
          state       <= RUN;
        end
        default: state <= RUN;
      endcase

      // Set after clear so a coinciding set event wins.
      if ((state != RUN) && bus.start_in) drop_q <= 1'b1;
    end
  end

  assign bus.sel_ack      = ack_q;
  assign bus.sel_err      = err_q;
  assign bus.start1       = start_q[0];
  assign bus.start2       = start_q[1];
  assign bus.start3       = start_q[2];
  assign bus.change       = change_q;
  assign bus.chan_en      = chan_en_q;
  assign bus.switching    = switching_q;
  assign bus.timeout_flag = timeout_q;
  assign bus.drop_flag    = drop_q;

endmodule

// File: tb/tb_chan_switch_seq.sv
module tb_chan_switch_seq;

  localparam int GUARD   = 16;
  localparam int TIMEOUT = 8;
  localparam int CW      = 13;

  typedef struct {
    int         cyc;
    bit         err;
    logic [1:0] ch;
  } resp_t;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
  } start_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  resp_t  resp_q[$];
  start_t start_q[$];

  logic [1:0] model_ch = 2'd0;
  bit         exp_to   = 1'b0;
  bit         exp_drop = 1'b0;

  chan_switch_seq_if bus ();

  chan_switch_seq #(
    .GUARD_CYC   (GUARD),
    .TIMEOUT_CYC (TIMEOUT),
    .CNT_W       (CW)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT shows a strobe.
  always @(negedge clk_sys) begin
    if (bus.sel_ack || bus.sel_err) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, bus.sel_err, bus.sel_ack}, 32'd0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_cyc", cyc, e.cyc);
        chk("resp_err", bus.sel_err, e.err);
        chk("resp_ack", bus.sel_ack, !e.err);
        if (!e.err) begin
          chk("ack_change", bus.change, e.ch);
          chk("ack_chan_en", bus.chan_en, 3'b001 << e.ch);
        end
      end
    end
    if (bus.start1 || bus.start2 || bus.start3) begin
      if (start_q.size() == 0) begin
        chk("unexpected_start", {bus.start3, bus.start2, bus.start1}, 32'd0);
      end else begin
        start_t s;
        s = start_q.pop_front();
        chk("start_cyc", cyc, s.cyc);
        chk("start_bits", {bus.start3, bus.start2, bus.start1}, 3'b001 << s.ch);
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk_sys); while (cyc < t);
  endtask

  task automatic set_busy(input logic [1:0] ch, input logic v);
    case (ch)
      2'd0:    bus.busy1 = v;
      2'd1:    bus.busy2 = v;
      default: bus.busy3 = v;
    endcase
  endtask

  // One request from RUN. d = cycles the old channel stays busy after the
  // strobe; drop_off = offset from the strobe cycle at which start_in is
  // pulsed while switching (ignored if outside the switch window).
  task automatic do_req(input logic [1:0] req, input bit st, input int d, input int drop_off);
    int    n;
    int    done;
    int    drain;
    bit    sw;
    resp_t r;
    start_t s;
    n    = cyc;
    done = n + 1;
    sw   = (req != 2'd3) && (req != model_ch);
    bus.sel_req   = req;
    bus.sel_valid = 1'b1;
    bus.start_in  = st;
    set_busy(model_ch, sw && (d > 0));
    if (st) begin
      s.cyc = n + 1; s.ch = model_ch;
      start_q.push_back(s);
    end
    if (req == 2'd3) begin
      r.cyc = n + 1; r.err = 1'b1; r.ch = 2'd0;
    end else if (!sw) begin
      r.cyc = n + 1; r.err = 1'b0; r.ch = req;
    end else begin
      drain = (d + 1 < TIMEOUT) ? d + 1 : TIMEOUT;
      done  = n + drain + GUARD + 2;
      r.cyc = done; r.err = 1'b0; r.ch = req;
      if (d >= TIMEOUT) exp_to = 1'b1;
    end
    resp_q.push_back(r);
    step();
    bus.sel_valid = 1'b0;
    bus.start_in  = 1'b0;
    if (sw) begin
      while (cyc < done) begin
        if (cyc == n + d + 1) set_busy(model_ch, 1'b0);
        bus.start_in = (cyc - n == drop_off);
        if (bus.start_in) exp_drop = 1'b1;
        step();
      end
      bus.start_in = 1'b0;
      set_busy(model_ch, 1'b0);
      model_ch = req;
    end
  endtask

  // Steady-state RUN check, optionally followed by a flag clear.
  task automatic settle_check(input bit clr);
    @(negedge clk_sys);
    chk("run_change", bus.change, model_ch);
    chk("run_chan_en", bus.chan_en, 3'b001 << model_ch);
    chk("run_switching", bus.switching, 1'b0);
    chk("timeout_flag", bus.timeout_flag, exp_to);
    chk("drop_flag", bus.drop_flag, exp_drop);
    if (clr) begin
      bus.flag_clr = 1'b1;
      exp_to   = 1'b0;
      exp_drop = 1'b0;
    end
    step();
    bus.flag_clr = 1'b0;
  endtask

  initial begin
    int n;
    resp_t r;
    bus.sel_req   = 2'd0;
    bus.sel_valid = 1'b0;
    bus.busy1     = 1'b0;
    bus.busy2     = 1'b0;
    bus.busy3     = 1'b0;
    bus.start_in  = 1'b0;
    bus.flag_clr  = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    @(negedge clk_sys);
    chk("rst_change", bus.change, 2'b00);
    chk("rst_chan_en", bus.chan_en, 3'b001);
    chk("rst_strobes", {bus.sel_ack, bus.sel_err, bus.start1, bus.start2, bus.start3}, 5'd0);
    chk("rst_flags", {bus.switching, bus.timeout_flag, bus.drop_flag}, 3'd0);
    step();

    // ch1 -> ch2 with busy low: enable drops, select moves, then enable rises.
    n = cyc;
    bus.sel_req   = 2'd1;
    bus.sel_valid = 1'b1;
    r.cyc = n + GUARD + 3; r.err = 1'b0; r.ch = 2'd1;
    resp_q.push_back(r);
    step();
    bus.sel_valid = 1'b0;
    wait_neg(n + 1);
    chk("sw_en_off", bus.chan_en, 3'b000);
    chk("sw_switching", bus.switching, 1'b1);
    wait_neg(n + GUARD + 1);
    chk("sw_change_old", bus.change, 2'b00);
    wait_neg(n + GUARD + 2);
    chk("sw_change_new", bus.change, 2'b01);
    chk("sw_en_still_off", bus.chan_en, 3'b000);
    wait_neg(n + GUARD + 3);
    chk("sw_en_new", bus.chan_en, 3'b010);
    step();
    model_ch = 2'd1;
    settle_check(1'b0);

    do_req(2'd3, 1'b0, 0, 0);       settle_check(1'b0);
    do_req(model_ch, 1'b0, 0, 0);   settle_check(1'b0);
    do_req(2'd0, 1'b0, TIMEOUT, 0); settle_check(1'b1);
    settle_check(1'b0);
    do_req(2'd2, 1'b0, 3, 0);       settle_check(1'b0);
    do_req(2'd3, 1'b1, 0, 0);       settle_check(1'b0);
    do_req(2'd1, 1'b0, 0, 5);       settle_check(1'b1);
    settle_check(1'b0);

    for (int i = 0; i < 40; i++) begin
      do_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 10)), int'($urandom_range(0, 60)));
      settle_check($urandom_range(0, 3) == 0);
    end

    // Reset in the middle of GUARD: no ack, reset values next cycle.
    n = cyc;
    bus.sel_req   = 2'((int'(model_ch) + 1) % 3);
    bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    while (cyc < n + 8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("mid_rst_change", bus.change, 2'b00);
    chk("mid_rst_chan_en", bus.chan_en, 3'b001);
    chk("mid_rst_outs", {bus.sel_ack, bus.sel_err, bus.switching, bus.timeout_flag, bus.drop_flag}, 5'd0);
    model_ch = 2'd0;
    exp_to   = 1'b0;
    exp_drop = 1'b0;
    repeat (GUARD + 10) step();
    settle_check(1'b0);

    chk("resp_q_empty", resp_q.size(), 0);
    chk("start_q_empty", start_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_switch_seq.md
Name: chan_switch_seq

Overview:
- Sequences safe switching of the active acquisition channel (1, 2 or 3) for the top-level control path.
- Drives the 2-bit `change` select and one-hot channel enables that the top-level control mux consumes.
- Routes host start pulses to the active channel only.
- Guarantees:
  - the old channel drains before the select moves;
  - a dead-time with all channels disabled separates old and new channel.

Parameters:
- GUARD_CYC, 16: dead-time cycles with all channel enables low during a switch (1..2^CNT_W-1).
- TIMEOUT_CYC, 4096: maximum cycles to wait for the old channel's busy to fall (1..2^CNT_W-1).
- CNT_W, 13: width of the shared drain/guard counter.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low (sampled on posedge clk_sys).
- sel_req  in  2  requested channel: 00=ch1, 01=ch2, 10=ch3, 11=illegal.
- sel_valid  in  1  one-cycle request strobe.
- sel_ack  out  1  one-cycle pulse: requested channel is active.
- sel_err  out  1  one-cycle pulse: illegal request rejected.
- busy1, busy2, busy3  in  1 each  channel sequence in progress.
- start_in  in  1  host start pulse.
- start1, start2, start3  out  1 each  start pulse forwarded to a channel.
- change  out  2  active channel select to the control mux.
- chan_en  out  3  one-hot channel enable; bit0=ch1.
- switching  out  1  high while not in RUN.
- timeout_flag  out  1  sticky: a drain timed out.
- drop_flag  out  1  sticky: a start_in was dropped.
- flag_clr  in  1  clears both sticky flags.

Behaviour:
- All outputs are registered.
- Reset values:
  - change=00, chan_en=001;
  - sel_ack, sel_err, start1..3, switching, timeout_flag, drop_flag all 0;
  - state=RUN, counter=0, target=00.
- Reset wins over every other input in the same cycle.
- Reset asserted mid-switch returns immediately to the reset state; no sel_ack is issued.
- States: RUN, DRAIN, GUARD, COMMIT.
- RUN, priority order:
  1. sel_valid & sel_req==11 -> sel_err=1 next cycle; stay in RUN.
  2. sel_valid & sel_req==change -> sel_ack=1 next cycle; stay in RUN.
  3. sel_valid otherwise -> target<=sel_req, chan_en<=000, counter<=0, switching<=1; go to DRAIN.
- DRAIN: watches busy of the old channel (indexed by change).
  - busy low -> counter<=0; go to GUARD.
  - counter==TIMEOUT_CYC-1 with busy still high -> timeout_flag<=1, counter<=0; go to GUARD.
  - otherwise counter increments.
- GUARD: counter increments each cycle.
  - When counter==GUARD_CYC-1 -> change<=target; go to COMMIT.
- COMMIT:
  - chan_en<=onehot(target), sel_ack<=1, switching<=0; go to RUN.
- Latency: sel_valid sampled in cycle 0 with old busy already low -> sel_ack and the new chan_en are high in cycle GUARD_CYC+3.
- change updates one cycle before chan_en goes high, so the mux select is stable before the enable.
- sel_valid outside RUN is ignored: no ack, no err. The requester waits for sel_ack or sel_err before re-issuing.
- start_in:
  - In RUN, start_k<=start_in, where k = change+1 (1-cycle latency).
  - Outside RUN, start_in is dropped and drop_flag<=1.
  - start_in together with a switching sel_valid in RUN: the start is forwarded to the old channel, and DRAIN then waits for its busy.
- Sticky flags:
  - flag_clr clears both.
  - If flag_clr and a set event coincide, the set wins.
- Counter saturates; it never wraps.

Decomposition:
- Shared package holds:
  - state encoding (RUN/DRAIN/GUARD/COMMIT);
  - channel codes CH1=00, CH2=01, CH3=10, CH_ILLEGAL=11;
  - onehot(code) function for chan_en.
- One sub-module, `chan_switch_cnt`, is natural: a saturating counter with clear and terminal-compare, reused for the drain timeout and the guard interval.

Test Plan:
- Reset, then idle 10 cycles -> change=00, chan_en=001, all strobes and flags 0.
- From ch1 with busy1=0, sel_req=01 strobe at cycle 0 (GUARD_CYC=16):
  - chan_en=000 from cycle 1;
  - change=01 at cycle 18;
  - chan_en=010 and sel_ack=1 at cycle 19.
- sel_req=11 -> sel_err pulses 1 cycle, no state change.
- sel_req equal to current channel -> sel_ack next cycle, chan_en unchanged.
- busy1 held high for the whole drain, TIMEOUT_CYC=8 -> timeout_flag=1 after 8 DRAIN cycles, switch completes; flag_clr then clears it.
- start_in in RUN on ch3 -> start3 pulses 1 cycle later, start1/start2 stay 0.
- start_in during GUARD -> no start pulse, drop_flag=1.
- rst_n=0 during GUARD -> reset values next cycle, no sel_ack.
